// File: rtl/arcade_inputs_pkg.sv
// Shared definitions for the arcade input path: matrix limits, board quirks
// and the one-hot row helper used by the key-matrix scanner.
package arcade_inputs_pkg;

    localparam int MAX_ROWS = 16;

    // Dakkochan panels wire their row strobes in reverse order.
    localparam bit DAKKOCHAN = 1'b0;

    function automatic logic [MAX_ROWS-1:0] onehot_row(input int idx, input int rows);
        logic [MAX_ROWS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_ROWS; i++) begin
            v[i] = (i == idx) && (idx < rows);
        end
        return v;
    endfunction

endpackage

// File: rtl/arcade_key_matrix_key_sync2.sv
// Two-flop synchroniser for a bus of independent, slowly changing key bits.
module key_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/arcade_key_matrix.sv
// Multiplexed keypad scanner: steps a row pointer on the game's mux strobe (or
// an internal divider) and returns the selected row as an active-low column byte.
module arcade_key_matrix
    import arcade_inputs_pkg::*;
#(
    parameter int ROWS      = 7,
    parameter int COLS      = 8,
    parameter int SEL_LOW   = 0,
    parameter int SYNC_KEYS = 1,
    parameter int AUTO_DIV  = 0,
    localparam int ROW_W    = $clog2(ROWS)
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROW_W-1:0]     start_row,
    input  logic                 load,
    input  logic                 strobe,
    input  logic [ROWS*COLS-1:0] keys,
    output logic [ROWS-1:0]      row_sel,
    output logic [ROW_W-1:0]     row_idx,
    output logic [COLS-1:0]      col_out,
    output logic                 wrap
);

    localparam int DIV_W   = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int DIV_MAX = (AUTO_DIV > 0) ? AUTO_DIV - 1 : 0;

    logic [ROWS*COLS-1:0] ks;
    logic [COLS-1:0]      key_row [ROWS];
    logic [ROW_W-1:0]     seed;
    logic [ROWS-1:0]      seed_onehot;
    logic [MAX_ROWS-1:0]  seed_onehot_full;
    logic [ROWS-1:0]      row_onehot;
    logic [ROW_W-1:0]     mux_row;
    logic [DIV_W-1:0]     div;
    logic                 strobe_r;
    logic                 adv;
    logic                 last_row;

    if (SYNC_KEYS != 0) begin : g_sync
        key_sync2 #(.WIDTH(ROWS*COLS)) u_sync (
            .clk_sys (clk_sys),
            .reset   (reset),
            .d       (keys),
            .q       (ks)
        );
    end else begin : g_nosync
        assign ks = keys;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign key_row[r] = ks[r*COLS +: COLS];
    end

    assign seed             = (int'(start_row) >= ROWS) ? '0 : start_row;
    assign seed_onehot_full = onehot_row(int'(seed), ROWS);
    assign seed_onehot      = seed_onehot_full[ROWS-1:0];
    assign last_row         = (row_idx == ROW_W'(ROWS - 1));
    assign mux_row          = DAKKOCHAN ? ROW_W'(ROWS - 1) - row_idx : row_idx;
    assign adv              = (AUTO_DIV == 0) ? (strobe & ~strobe_r) : (div == DIV_W'(DIV_MAX));
    assign row_sel          = (SEL_LOW != 0) ? ~row_onehot : row_onehot;

    always_ff @(posedge clk_sys) begin
        if (reset || load || AUTO_DIV == 0) begin
            div <= '0;
        end else if (enable) begin
            div <= (div == DIV_W'(DIV_MAX)) ? '0 : div + 1'b1;
        end
    end

    // NOTE: all state here uses <= so every branch sees the pre-edge row_idx,
    // which is what makes wrap line up with the ROWS-1 -> 0 step.
    always_ff @(posedge clk_sys) begin
        // Tracked through reset as well, so a strobe held high across reset is not an edge.
        strobe_r <= strobe;
        if (reset) begin
            row_idx    <= seed;
            row_onehot <= seed_onehot;
            col_out    <= '1;
            wrap       <= 1'b0;
        end else begin
            wrap    <= 1'b0;
            col_out <= ~key_row[mux_row];
            if (load) begin
                row_idx    <= seed;
                row_onehot <= seed_onehot;
            end else if (enable && adv) begin
                row_idx    <= last_row ? '0 : row_idx + 1'b1;
                row_onehot <= {row_onehot[ROWS-2:0], row_onehot[ROWS-1]};
                wrap       <= last_row;
            end
        end
    end

endmodule
